// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the memory-channel arbiter.
// Requester IDs double as the owner tag carried through a transaction.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BITS_DFLT = 28;
    localparam int MEM_DATA_BITS_DFLT = 128;
    localparam int MEM_MASK_BITS_DFLT = MEM_DATA_BITS_DFLT / 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_ID_IC = 1'b0,
        ARB_ID_DC = 1'b1
    } arb_id_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner select between icache and dcache; zero latency, no state.
// MEM_ARB_RR_EN: alternate on conflict using last_grant; otherwise dcache always wins.
module mem_arb_sel
    import mem_arbiter_pkg::*;
(
    input  logic    ic_vld_i,
    input  logic    dc_vld_i,
`ifdef MEM_ARB_RR_EN
    input  arb_id_e last_grant_i,
`endif
    output logic    any_vld_o,
    output arb_id_e winner_o
);

    always_comb begin
        any_vld_o = ic_vld_i | dc_vld_i;
`ifdef MEM_ARB_RR_EN
        if (ic_vld_i && dc_vld_i) begin
            winner_o = (last_grant_i == ARB_ID_IC) ? ARB_ID_DC : ARB_ID_IC;
        end else begin
            winner_o = dc_vld_i ? ARB_ID_DC : ARB_ID_IC;
        end
`else
        winner_o = dc_vld_i ? ARB_ID_DC : ARB_ID_IC;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request/response channel between icache and dcache, one transaction in flight.
// Accept in IDLE -> mem_req_valid next cycle; requests stall in REQ on !mem_req_ready. Option: MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DFLT,
    parameter int MEM_DATA_BITS = MEM_DATA_BITS_DFLT,
    parameter int MEM_MASK_BITS = MEM_DATA_BITS / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ic_req_valid,
    output logic                     ic_req_ready,
    input  logic [MEM_ADDR_BITS-1:0] ic_req_addr,
    output logic                     ic_resp_valid,
    output logic [MEM_DATA_BITS-1:0] ic_resp_data,
    input  logic                     dc_req_valid,
    output logic                     dc_req_ready,
    input  logic                     dc_req_rw,
    input  logic [MEM_ADDR_BITS-1:0] dc_req_addr,
    input  logic [MEM_DATA_BITS-1:0] dc_req_data,
    input  logic [MEM_MASK_BITS-1:0] dc_req_mask,
    output logic                     dc_resp_valid,
    output logic [MEM_DATA_BITS-1:0] dc_resp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic [MEM_DATA_BITS-1:0] mem_req_data,
    output logic [MEM_MASK_BITS-1:0] mem_req_mask,
    input  logic                     mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
    output logic                     proto_err
);

    arb_state_e               state_q, state_d;
    arb_id_e                  owner_q, owner_d;
    logic                     rw_q, rw_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [MEM_DATA_BITS-1:0] data_q, data_d;
    logic [MEM_MASK_BITS-1:0] mask_q, mask_d;
    logic                     proto_err_q, proto_err_d;
    logic                     any_vld;
    arb_id_e                  winner;
`ifdef MEM_ARB_RR_EN
    arb_id_e                  last_grant_q, last_grant_d;
`endif

    mem_arb_sel u_sel (
        .ic_vld_i     (ic_req_valid),
        .dc_vld_i     (dc_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .any_vld_o    (any_vld),
        .winner_o     (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= ARB_ID_IC;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            proto_err_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= ARB_ID_IC;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            proto_err_q <= proto_err_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        data_d        = data_q;
        mask_d        = mask_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d  = last_grant_q;
`endif
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        ic_resp_valid = 1'b0;
        dc_resp_valid = 1'b0;
        // A response is only legal while a read is waiting for it.
        proto_err_d   = proto_err_q | (mem_resp_valid && (state_q != ARB_RESP));

        case (state_q)
            ARB_IDLE: begin
                if (any_vld) begin
                    state_d = ARB_REQ;
                    owner_d = winner;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = winner;
`endif
                    if (winner == ARB_ID_DC) begin
                        dc_req_ready = 1'b1;
                        rw_d         = dc_req_rw;
                        addr_d       = dc_req_addr;
                        data_d       = dc_req_data;
                        mask_d       = dc_req_mask;
                    end else begin
                        ic_req_ready = 1'b1;
                        rw_d         = 1'b0;
                        addr_d       = ic_req_addr;
                        data_d       = '0;
                        mask_d       = '0;
                    end
                end
            end
            ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = rw_q ? ARB_IDLE : ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (mem_resp_valid) begin
                    if (owner_q == ARB_ID_DC) begin
                        dc_resp_valid = 1'b1;
                    end else begin
                        ic_resp_valid = 1'b1;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign mem_req_rw   = rw_q;
    assign mem_req_addr = addr_q;
    assign mem_req_data = data_q;
    assign mem_req_mask = mask_q;
    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers and a memory responder feed the DUT,
// expected grants/requests/responses are queued by the directed tests and popped by a monitor.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
    } mreq_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req_valid, ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_resp_valid;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data;
    logic [MW-1:0] dc_req_mask;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [MW-1:0] mem_req_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          proto_err;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .proto_err(proto_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [255:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {32'hDEADBEEF, 4'h0, a, 64'h0123_4567_89AB_CDEF};
    endfunction

    bit            exp_grant[$];
    mreq_t         exp_mem[$];
    logic [DW-1:0] exp_ic[$];
    logic [DW-1:0] exp_dc[$];
    logic [AW-1:0] ic_jobs[$];
    mreq_t         dc_jobs[$];

    task automatic exp_ic_txn(input logic [AW-1:0] a);
        exp_grant.push_back(1'b0);
        exp_mem.push_back({1'b0, a, {DW{1'b0}}, {MW{1'b0}}});
        exp_ic.push_back(line_of(a));
    endtask

    task automatic exp_dc_txn(input logic rw, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [MW-1:0] m, input bit resp);
        exp_grant.push_back(1'b1);
        exp_mem.push_back({rw, a, d, m});
        if (!rw && resp) exp_dc.push_back(line_of(a));
    endtask

    // Requester drivers: drive at negedge+1, observe ready at negedge+2.
    bit ic_act = 0, ic_acc = 0;
    initial begin
        ic_req_valid = 1'b0;
        ic_req_addr  = '0;
        forever begin
            @(negedge clk); #1;
            if (ic_act && ic_acc) begin ic_act = 0; ic_req_valid = 1'b0; end
            if (!ic_act && ic_jobs.size() > 0) begin
                ic_req_addr  = ic_jobs.pop_front();
                ic_req_valid = 1'b1;
                ic_act = 1; ic_acc = 0;
            end
            #1;
            if (ic_act && ic_req_ready && !rst) ic_acc = 1;
        end
    end

    bit dc_act = 0, dc_acc = 0;
    initial begin
        mreq_t j;
        dc_req_valid = 1'b0;
        {dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask} = '0;
        forever begin
            @(negedge clk); #1;
            if (dc_act && dc_acc) begin dc_act = 0; dc_req_valid = 1'b0; end
            if (!dc_act && dc_jobs.size() > 0) begin
                j = dc_jobs.pop_front();
                {dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask} = j;
                dc_req_valid = 1'b1;
                dc_act = 1; dc_acc = 0;
            end
            #1;
            if (dc_act && dc_req_ready && !rst) dc_acc = 1;
        end
    end

    // Memory responder: stall_left cycles of !ready per request, read data resp_delay cycles after RESP entry.
    int            stall_left = 0;
    int            resp_delay = 1;
    bit            inject = 0;
    bit            pend = 0;
    int            pend_cnt = 0;
    logic [DW-1:0] pend_data = '0;
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk); #1;
            mem_resp_valid = 1'b0;
            if (inject) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {4{32'h0BAD_0BAD}};
                inject = 0;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = pend_data;
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
            mem_req_ready = (stall_left == 0);
            #1;
            if (!rst && mem_req_valid) begin
                if (mem_req_ready) begin
                    if (!mem_req_rw) begin
                        pend = 1; pend_cnt = resp_delay; pend_data = line_of(mem_req_addr);
                    end
                end else begin
                    stall_left--;
                end
            end
        end
    end

    // Monitor: samples settled values at negedge+2.
    int    cyc = 0;
    bit    acc_prev = 0, hold_prev = 0;
    mreq_t held;
    int    req_len = 0;
    int    w_hs_cyc = -1, w_req_len = 0, last_dc_resp_cyc = -1, last_ic_grant_cyc = -1;
    initial begin
        mreq_t cur;
        bit    id;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (rst) begin
                acc_prev = 0; hold_prev = 0; req_len = 0;
            end else begin
                cur = {mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask};
                if (acc_prev) check("req_latency", 256'(mem_req_valid), 256'(1));
                acc_prev = 0;
                if (ic_req_ready || dc_req_ready) begin
                    check("one_ready", 256'(ic_req_ready & dc_req_ready), 256'(0));
                    id = dc_req_ready;
                    if (exp_grant.size() == 0) unexpected("grant", 256'(id));
                    else check("grant", 256'(id), 256'(exp_grant.pop_front()));
                    if (!id) last_ic_grant_cyc = cyc;
                    acc_prev = 1;
                end
                if (mem_req_valid) begin
                    if (hold_prev) check("req_stable", 256'(cur), 256'(held));
                    req_len++;
                    if (mem_req_ready) begin
                        if (exp_mem.size() == 0) unexpected("mem_req", 256'(cur));
                        else check("mem_req", 256'(cur), 256'(exp_mem.pop_front()));
                        if (mem_req_rw) begin w_hs_cyc = cyc; w_req_len = req_len; end
                        req_len = 0; hold_prev = 0;
                    end else begin
                        hold_prev = 1; held = cur;
                    end
                end
                if (ic_resp_valid || dc_resp_valid)
                    check("one_resp", 256'(ic_resp_valid & dc_resp_valid), 256'(0));
                if (ic_resp_valid) begin
                    if (exp_ic.size() == 0) unexpected("ic_resp", 256'(ic_resp_data));
                    else check("ic_resp", 256'(ic_resp_data), 256'(exp_ic.pop_front()));
                end
                if (dc_resp_valid) begin
                    if (exp_dc.size() == 0) unexpected("dc_resp", 256'(dc_resp_data));
                    else check("dc_resp", 256'(dc_resp_data), 256'(exp_dc.pop_front()));
                    last_dc_resp_cyc = cyc;
                end
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((exp_grant.size() > 0 || exp_mem.size() > 0 || exp_ic.size() > 0 ||
                exp_dc.size() > 0 || ic_jobs.size() > 0 || dc_jobs.size() > 0 ||
                ic_act || dc_act || pend) && n < 300) begin
            @(negedge clk); #3;
            n++;
        end
        check(name, 256'(n < 300), 256'(1));
        repeat (2) @(negedge clk);
        #3;
    endtask

    task automatic idle_outputs(input string name);
        check(name, 256'({ic_req_ready, dc_req_ready, mem_req_valid, ic_resp_valid, dc_resp_valid}), 256'(0));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        idle_outputs("reset_outputs");
        check("reset_proto_err", 256'(proto_err), 256'(0));
        check("reset_fields", 256'({mem_req_rw, mem_req_addr, mem_req_mask}), 256'(0));

        // Single icache read
        exp_ic_txn(28'h0000040);
        ic_jobs.push_back(28'h0000040);
        drain("ic_read_done");

        // dcache write with 3 stall cycles; icache queued behind it
        stall_left = 3;
        exp_dc_txn(1'b1, 28'h0000100, 128'h1234, 16'h000F, 0);
        dc_jobs.push_back({1'b1, 28'h0000100, 128'h1234, 16'h000F});
        n = 0;
        while (exp_grant.size() > 0 && n < 50) begin @(negedge clk); #3; n++; end
        exp_ic_txn(28'h0000080);
        ic_jobs.push_back(28'h0000080);
        drain("dc_write_done");
        check("write_req_len", 256'(w_req_len), 256'(4));
        check("write_then_idle", 256'(last_ic_grant_cyc), 256'(w_hs_cyc + 1));

        // First conflict: dcache wins in both builds
        exp_dc_txn(1'b0, 28'h0000020, '0, '0, 1);
        exp_ic_txn(28'h0000010);
        ic_jobs.push_back(28'h0000010);
        dc_jobs.push_back({1'b0, 28'h0000020, {DW{1'b0}}, {MW{1'b0}}});
        drain("conflict1_done");
        check("ic_after_dc_resp", 256'(last_ic_grant_cyc), 256'(last_dc_resp_cyc + 1));

        // Lone dcache read, then second conflict
        exp_dc_txn(1'b0, 28'h0000030, '0, '0, 1);
        dc_jobs.push_back({1'b0, 28'h0000030, {DW{1'b0}}, {MW{1'b0}}});
        drain("dc_lone_done");
`ifdef MEM_ARB_RR_EN
        exp_ic_txn(28'h0000018);
        exp_dc_txn(1'b0, 28'h0000028, '0, '0, 1);
`else
        exp_dc_txn(1'b0, 28'h0000028, '0, '0, 1);
        exp_ic_txn(28'h0000018);
`endif
        ic_jobs.push_back(28'h0000018);
        dc_jobs.push_back({1'b0, 28'h0000028, {DW{1'b0}}, {MW{1'b0}}});
        drain("conflict2_done");

        // Stray response while idle
        check("proto_err_before", 256'(proto_err), 256'(0));
        inject = 1;
        repeat (3) @(negedge clk);
        #3;
        check("proto_err_set", 256'(proto_err), 256'(1));
        exp_ic_txn(28'h0000060);
        ic_jobs.push_back(28'h0000060);
        drain("ic_after_err_done");
        check("proto_err_sticky", 256'(proto_err), 256'(1));

        // Reset while a dcache read waits in RESP
        resp_delay = 4;
        exp_dc_txn(1'b0, 28'h0000200, '0, '0, 0);
        dc_jobs.push_back({1'b0, 28'h0000200, {DW{1'b0}}, {MW{1'b0}}});
        n = 0;
        while (exp_mem.size() > 0 && n < 50) begin @(negedge clk); #3; n++; end
        check("rst_handshake_seen", 256'(n < 50), 256'(1));
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        #1;
        idle_outputs("post_rst_outputs");
        check("post_rst_proto_err", 256'(proto_err), 256'(0));
        repeat (6) @(negedge clk);
        #3;
        check("late_resp_proto_err", 256'(proto_err), 256'(1));
        resp_delay = 1;
        exp_ic_txn(28'h0000300);
        ic_jobs.push_back(28'h0000300);
        drain("ic_after_rst_done");

        // Back-to-back: four reads from each side, both held valid
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            exp_dc_txn(1'b0, 28'h0000400 + 28'(i), '0, '0, 1);
            exp_ic_txn(28'h0000500 + 28'(i));
        end
`else
        for (int i = 0; i < 4; i++) exp_dc_txn(1'b0, 28'h0000400 + 28'(i), '0, '0, 1);
        for (int i = 0; i < 4; i++) exp_ic_txn(28'h0000500 + 28'(i));
`endif
        for (int i = 0; i < 4; i++) begin
            dc_jobs.push_back({1'b0, 28'h0000400 + 28'(i), {DW{1'b0}}, {MW{1'b0}}});
            ic_jobs.push_back(28'h0000500 + 28'(i));
        end
        drain("b2b_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
